// File: rtl/edge_overlay.sv
// edge_overlay: merges the Sobel edge map with delay-aligned HDMI video and counts edge pixels per frame.
// Latency: 1 cycle from edge_* inputs, DELAY+1 cycles from hdmi_* inputs.
// Backpressure: none; free-running pixel stream, one pixel accepted and produced every clk.
module edge_overlay #(
    parameter int          DELAY      = 2,
    parameter logic [23:0] EDGE_COLOR = 24'h00FF00,
    parameter int          CNT_W      = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hdmi_de,
    input  logic             hdmi_vsync,
    input  logic             hdmi_hsync,
    input  logic [23:0]      hdmi_data_in,
    input  logic             edge_de,
    input  logic             edge_vsync,
    input  logic             edge_hsync,
    input  logic [23:0]      edge_data_out,
    input  logic [1:0]       mode_in,
    output logic             out_de,
    output logic             out_vsync,
    output logic             out_hsync,
    output logic [23:0]      out_data,
    output logic [CNT_W-1:0] edge_count,
    output logic             edge_count_valid
);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_EDGE    = 2'd1;
    localparam logic [1:0] MODE_OVERLAY = 2'd2;
    localparam logic [1:0] MODE_DIM     = 2'd3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } raw_t;

    raw_t             chain [DELAY];
    raw_t             raw_q;
    logic [23:0]      raw_d;
    logic             raw_de_d;
    logic             raw_vs_d;
    logic             raw_hs_d;
    logic             unused_raw_sync;

    logic [1:0]       mode_q;
    logic             prev_vsync;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             is_edge;
    logic             vs_rise;
    logic [23:0]      pix_next;

    // Raw video is delayed so that it lines up with the edge stage's pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= '{hs: hdmi_hsync, vs: hdmi_vsync, de: hdmi_de, rgb: hdmi_data_in};
            for (int i = 1; i < DELAY; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign raw_q    = chain[DELAY-1];
    assign raw_d    = raw_q.rgb;
    assign raw_de_d = raw_q.de;
    assign raw_vs_d = raw_q.vs;
    assign raw_hs_d = raw_q.hs;

    // Output timing is taken from the edge stream, so the delayed raw syncs are not consumed.
    assign unused_raw_sync = ^{raw_de_d, raw_vs_d, raw_hs_d};

    assign is_edge = edge_de & (edge_data_out != 24'd0);
    assign vs_rise = edge_vsync & ~prev_vsync;
    assign cnt_inc = (is_edge && (run_cnt != '1)) ? run_cnt + CNT_W'(1) : run_cnt;

    always_comb begin
        pix_next = 24'd0;
        if (edge_de) begin
            case (mode_q)
                MODE_PASS:    pix_next = raw_d;
                MODE_EDGE:    pix_next = is_edge ? 24'hFFFFFF : 24'd0;
                MODE_OVERLAY: pix_next = is_edge ? EDGE_COLOR : raw_d;
                MODE_DIM:     pix_next = is_edge ? EDGE_COLOR :
                                         {1'b0, raw_d[23:17], 1'b0, raw_d[15:9], 1'b0, raw_d[7:1]};
                default:      pix_next = 24'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_de           <= 1'b0;
            out_vsync        <= 1'b0;
            out_hsync        <= 1'b0;
            out_data         <= 24'd0;
            edge_count       <= '0;
            edge_count_valid <= 1'b0;
            mode_q           <= MODE_PASS;
            prev_vsync       <= 1'b0;
            run_cnt          <= '0;
        end else begin
            out_de     <= edge_de;
            out_vsync  <= edge_vsync;
            out_hsync  <= edge_hsync;
            out_data   <= pix_next;
            prev_vsync <= edge_vsync;
            // The vs_rise pixel itself still belongs to the closing frame: it is counted and uses the old mode.
            if (vs_rise) begin
                mode_q           <= mode_in;
                edge_count       <= cnt_inc;
                run_cnt          <= '0;
                edge_count_valid <= 1'b1;
            end else begin
                run_cnt          <= cnt_inc;
                edge_count_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_overlay.sv
// Directed bench for edge_overlay: table-driven pixel-mux vectors plus sequences for timing, counting and reset.
module tb_edge_overlay;

    localparam int DELAY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdmi_de, hdmi_vsync, hdmi_hsync;
    logic [23:0] hdmi_data_in;
    logic        edge_de, edge_vsync, edge_hsync;
    logic [23:0] edge_data_out;
    logic [1:0]  mode_in;

    logic        out_de, out_vsync, out_hsync;
    logic [23:0] out_data;
    logic [21:0] edge_count;
    logic        edge_count_valid;

    logic        s_de, s_vsync, s_hsync;
    logic [23:0] s_data;
    logic [2:0]  s_count;
    logic        s_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_overlay #(.DELAY(DELAY), .EDGE_COLOR(24'h00FF00), .CNT_W(22)) dut (
        .clk(clk), .reset(reset),
        .hdmi_de(hdmi_de), .hdmi_vsync(hdmi_vsync), .hdmi_hsync(hdmi_hsync), .hdmi_data_in(hdmi_data_in),
        .edge_de(edge_de), .edge_vsync(edge_vsync), .edge_hsync(edge_hsync), .edge_data_out(edge_data_out),
        .mode_in(mode_in),
        .out_de(out_de), .out_vsync(out_vsync), .out_hsync(out_hsync), .out_data(out_data),
        .edge_count(edge_count), .edge_count_valid(edge_count_valid)
    );

    edge_overlay #(.DELAY(DELAY), .EDGE_COLOR(24'h00FF00), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .hdmi_de(hdmi_de), .hdmi_vsync(hdmi_vsync), .hdmi_hsync(hdmi_hsync), .hdmi_data_in(hdmi_data_in),
        .edge_de(edge_de), .edge_vsync(edge_vsync), .edge_hsync(edge_hsync), .edge_data_out(edge_data_out),
        .mode_in(mode_in),
        .out_de(s_de), .out_vsync(s_vsync), .out_hsync(s_hsync), .out_data(s_data),
        .edge_count(s_count), .edge_count_valid(s_valid)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        de;
        logic [23:0] edata;
        logic [23:0] raw;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        edge_de       = 1'b0;
        edge_data_out = 24'd0;
        mode_in       = m;
        edge_vsync    = 1'b1;
        tick();
        edge_vsync    = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b1, 24'h000000, 24'h123456, 24'h123456};
        vecs[1]  = '{2'd0, 1'b1, 24'h000001, 24'h123456, 24'h123456};
        vecs[2]  = '{2'd0, 1'b0, 24'h000000, 24'hABCDEF, 24'h000000};
        vecs[3]  = '{2'd1, 1'b1, 24'h000100, 24'h123456, 24'hFFFFFF};
        vecs[4]  = '{2'd1, 1'b1, 24'h000000, 24'h123456, 24'h000000};
        vecs[5]  = '{2'd1, 1'b0, 24'hFFFFFF, 24'h123456, 24'h000000};
        vecs[6]  = '{2'd2, 1'b1, 24'h000001, 24'h123456, 24'h00FF00};
        vecs[7]  = '{2'd2, 1'b1, 24'h000000, 24'h808080, 24'h808080};
        vecs[8]  = '{2'd2, 1'b0, 24'h000001, 24'h808080, 24'h000000};
        vecs[9]  = '{2'd3, 1'b1, 24'h000000, 24'hFF8001, 24'h7F4000};
        vecs[10] = '{2'd3, 1'b1, 24'h800000, 24'hFF8001, 24'h00FF00};
        vecs[11] = '{2'd3, 1'b0, 24'h000000, 24'hFF8001, 24'h000000};
        vecs[12] = '{2'd3, 1'b1, 24'h000000, 24'h010101, 24'h000000};

        // Reset with busy inputs: every output must read zero.
        reset = 1'b1;
        hdmi_de = 1'b1; hdmi_vsync = 1'b0; hdmi_hsync = 1'b0; hdmi_data_in = 24'hA5A5A5;
        edge_de = 1'b1; edge_vsync = 1'b1; edge_hsync = 1'b1; edge_data_out = 24'hFFFFFF;
        mode_in = 2'd3;
        tick();
        tick();
        chk("reset_out_de", out_de, 1'b0);
        chk("reset_out_vsync", out_vsync, 1'b0);
        chk("reset_out_hsync", out_hsync, 1'b0);
        chk("reset_out_data", out_data, 24'd0);
        chk("reset_edge_count", edge_count, 22'd0);
        chk("reset_count_valid", edge_count_valid, 1'b0);

        // Ramp in mode 0: out_data after edge e shows the raw value sampled DELAY edges earlier.
        reset = 1'b0;
        edge_vsync = 1'b0; edge_hsync = 1'b0; edge_data_out = 24'd0; mode_in = 2'd0;
        for (int e = 0; e < 8; e++) begin
            hdmi_data_in = 24'h000100 + 24'(e);
            edge_de      = (e >= 2);
            tick();
            chk($sformatf("ramp_de_%0d", e), out_de, (e >= 2));
            chk($sformatf("ramp_data_%0d", e), out_data, (e >= 2) ? 24'h000100 + 24'(e - 2) : 24'd0);
        end

        // Pixel-mux table: raw is held for DELAY cycles so that it aligns with the edge pixel.
        for (int i = 0; i < 13; i++) begin
            if (i == 0 || vecs[i].mode != vecs[i-1].mode) set_mode(vecs[i].mode);
            edge_de       = 1'b0;
            edge_data_out = 24'd0;
            hdmi_data_in  = vecs[i].raw;
            repeat (DELAY) tick();
            edge_de       = vecs[i].de;
            edge_data_out = vecs[i].edata;
            tick();
            chk($sformatf("vec_%0d_mode%0d", i, vecs[i].mode), out_data, vecs[i].exp);
        end

        // Mode 2 back-to-back pixels with a real pipeline of raw values.
        set_mode(2'd2);
        hdmi_data_in = 24'h123456; tick();
        hdmi_data_in = 24'h808080; tick();
        hdmi_data_in = 24'h000000;
        edge_de = 1'b1; edge_data_out = 24'h000001; edge_hsync = 1'b1;
        tick();
        chk("ovl_seq_edge", out_data, 24'h00FF00);
        chk("ovl_seq_hsync", out_hsync, 1'b1);
        edge_data_out = 24'h000000; edge_hsync = 1'b0;
        tick();
        chk("ovl_seq_raw", out_data, 24'h808080);
        chk("ovl_seq_hsync_lo", out_hsync, 1'b0);

        // Frame with 5 edges among 8 active pixels, plus a blanking pixel with nonzero data.
        set_mode(2'd0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] mask;
            mask = 8'b10101101;
            edge_de = 1'b1;
            edge_data_out = mask[k] ? 24'h000010 : 24'h000000;
            tick();
        end
        edge_de = 1'b0; edge_data_out = 24'hFFFFFF;
        tick();
        chk("cnt5_no_pulse_yet", edge_count_valid, 1'b0);
        edge_data_out = 24'd0; edge_vsync = 1'b1;
        tick();
        chk("cnt5_count", edge_count, 22'd5);
        chk("cnt5_valid", edge_count_valid, 1'b1);
        chk("cnt5_sat_inst", s_count, 3'd5);
        chk("cnt5_out_vsync", out_vsync, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("vs_held_valid_%0d", k), edge_count_valid, 1'b0);
        end
        chk("vs_held_count", edge_count, 22'd5);

        // Empty frame reports zero.
        edge_vsync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge_de = 1'b1; edge_data_out = 24'd0;
            tick();
        end
        edge_vsync = 1'b1;
        tick();
        chk("cnt0_count", edge_count, 22'd0);
        chk("cnt0_valid", edge_count_valid, 1'b1);

        // 9 edges plus one on the vs_rise pixel: 10 total, saturating at 7 in the 3-bit instance.
        edge_vsync = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            edge_de = 1'b1; edge_data_out = 24'h000001;
            tick();
        end
        edge_vsync = 1'b1;
        tick();
        chk("cnt10_count", edge_count, 22'd10);
        chk("cnt10_valid", edge_count_valid, 1'b1);
        chk("cnt10_sat_count", s_count, 3'd7);
        chk("cnt10_sat_valid", s_valid, 1'b1);
        edge_vsync = 1'b0; edge_de = 1'b0; edge_data_out = 24'd0;
        tick();

        // mode_in changes mid-frame; only the vs_rise loads it, effective the next pixel.
        hdmi_data_in = 24'h445566; mode_in = 2'd1;
        repeat (DELAY) tick();
        edge_de = 1'b1; edge_data_out = 24'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("modesw_hold_%0d", k), out_data, 24'h445566);
        end
        edge_vsync = 1'b1;
        tick();
        chk("modesw_rise_pixel", out_data, 24'h445566);
        tick();
        chk("modesw_after_noedge", out_data, 24'h000000);
        edge_data_out = 24'h000001;
        tick();
        chk("modesw_after_edge", out_data, 24'hFFFFFF);
        edge_vsync = 1'b0;
        tick();
        edge_vsync = 1'b1;
        tick();
        chk("pre_reset_count", edge_count, 22'd3);

        // Reset mid-frame with active inputs.
        reset = 1'b1; edge_hsync = 1'b1; hdmi_data_in = 24'h224466;
        tick();
        chk("midrst_out_de", out_de, 1'b0);
        chk("midrst_out_vsync", out_vsync, 1'b0);
        chk("midrst_out_hsync", out_hsync, 1'b0);
        chk("midrst_out_data", out_data, 24'd0);
        chk("midrst_edge_count", edge_count, 22'd0);
        chk("midrst_valid", edge_count_valid, 1'b0);
        chk("midrst_sat_count", s_count, 3'd0);

        // Mode back to 0 and the delay chain drained: first DELAY active pixels are black.
        reset = 1'b0; edge_vsync = 1'b0; edge_hsync = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk($sformatf("postrst_data_%0d", e), out_data, (e >= DELAY) ? 24'h224466 : 24'd0);
        end
        chk("postrst_no_pulse", edge_count_valid, 1'b0);

        // vsync already high on the first cycle after reset is a frame boundary.
        reset = 1'b1;
        tick();
        reset = 1'b0; edge_vsync = 1'b1;
        tick();
        chk("rst_vs_high_valid", edge_count_valid, 1'b1);
        chk("rst_vs_high_count", edge_count, 22'd1);
        tick();
        chk("rst_vs_high_single", edge_count_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_overlay.md
Name: edge_overlay

Overview:
- Downstream consumer of the Sobel edge-detection stage.
- Merges the binary edge map with the original HDMI video, which it delays internally to align with the edge stream. Produces one display stream, in one of four frame-selectable modes.
- Also reports the number of edge pixels in each frame, at every frame boundary, for software and threshold tuning.

Parameters:
- DELAY, 2, cycles by which the raw video/sync is delayed to align with the edge stream; legal range 1..16.
- EDGE_COLOR, 24'h00FF00, RGB value painted on edge pixels in overlay modes.
- CNT_W, 22, width of the per-frame edge pixel counter.

Ports:
- clk  in  1  pixel clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- hdmi_de  in  1  raw video data enable.
- hdmi_vsync  in  1  raw vsync; unused except in the delay chain.
- hdmi_hsync  in  1  raw hsync; unused except in the delay chain.
- hdmi_data_in  in  24  raw RGB {R[23:16],G[15:8],B[7:0]}.
- edge_de  in  1  data enable from the edge stage.
- edge_vsync  in  1  vsync from the edge stage; active-high.
- edge_hsync  in  1  hsync from the edge stage.
- edge_data_out  in  24  edge map; any nonzero value means edge.
- mode_in  in  2  requested mode: 0 pass, 1 edge-only, 2 overlay, 3 dimmed overlay.
- out_de  out  1  output data enable.
- out_vsync  out  1  output vsync.
- out_hsync  out  1  output hsync.
- out_data  out  24  output RGB.
- edge_count  out  CNT_W  edge pixel count of the last completed frame.
- edge_count_valid  out  1  one-cycle pulse when edge_count updates.

Behaviour:
- Reset values:
  - All outputs 0.
  - Delay chain contents 0.
  - Active mode 0.
  - Running counter 0.
  - Previous-vsync register 0.
- Delay chain: hdmi_data_in, hdmi_de, hdmi_vsync and hdmi_hsync pass through DELAY register stages, giving raw_d, raw_de_d, raw_vs_d and raw_hs_d.
- Output timing follows the edge stream:
  - out_de, out_vsync and out_hsync are edge_de, edge_vsync and edge_hsync registered once.
  - Latency is 1 cycle from the edge_* inputs and DELAY+1 cycles from the hdmi_* inputs.
- Edge pixel: is_edge = edge_de AND (edge_data_out != 0).
- Pixel mux (registered; same cycle as the syncs):
  - edge_de = 0: out_data = 0 in all modes (blanking is forced black).
  - Mode 0: out_data = raw_d.
  - Mode 1: out_data = 24'hFFFFFF if is_edge, else 0.
  - Mode 2: out_data = EDGE_COLOR if is_edge, else raw_d.
  - Mode 3: out_data = EDGE_COLOR if is_edge, else each 8-bit channel of raw_d shifted right by 1 (truncating).
- Frame boundary: vs_rise = edge_vsync AND NOT prev_vsync, where prev_vsync is edge_vsync registered once.
- Mode update: the active mode loads mode_in only on the cycle of vs_rise. Changes to mode_in at any other time have no effect until the next vs_rise. A new mode first applies to the pixel sampled on the cycle after vs_rise.
- Counter, normal cycle: if is_edge, the running counter increments, saturating at all-ones. It never wraps.
- Counter, on vs_rise:
  - edge_count <= running counter + is_edge, saturating.
  - The running counter clears to 0.
  - edge_count_valid = 1 for exactly that one registered cycle.
- Counter, other cycles: edge_count holds and edge_count_valid = 0.
- First frame after reset: the first vs_rise reports a partial count; it is not suppressed.
- Vsync held high: only a single vs_rise occurs, so there is one valid pulse per frame.
- Reset mid-frame: all state clears on the next clock edge.
  - Delay-chain output is zeros for DELAY cycles afterwards, so in mode 0 the first DELAY active pixels output are black.
  - A vs_rise is detected if edge_vsync is already high on the first cycle after reset deasserts.

Test Plan:
- Mode 0, DELAY=2, ramp hdmi_data_in=N at cycle N, edge_de=1 from cycle 2 -> out_data at cycle N+3 equals N. out_de rises at cycle 3.
- Mode 2, edge_data_out=24'h000001 on one pixel with raw=24'h123456, and 0 on the next pixel with raw=24'h808080 -> outputs 24'h00FF00, then 24'h808080.
- Mode 3, raw=24'hFF8001, no edge -> out_data=24'h7F4000. In blanking (edge_de=0) with raw nonzero -> out_data=0.
- Frame of 5 edge pixels, then vsync rise -> edge_count=5 with a one-cycle valid pulse. The next frame with 0 edges reports 0. The count resets between frames.
- mode_in switched 0->1 mid-frame -> output stays mode 0 until vs_rise, then is edge-only from the following cycle.
- CNT_W=3 with 10 edges in a frame -> edge_count=7 (saturated). Reset asserted mid-frame -> all outputs 0 on the next edge, and mode returns to 0.
